// File: rtl/axi_defs.sv
// rtl/axi_defs.sv - shared AXI4-Lite definitions
// Purpose: response codes shared by the AXI4-Lite master and slave blocks.
// Ports: none (package).
package axi_defs;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] WSTRB_ALL   = 4'hF;

endpackage

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - AXI4-Lite master driven by one-cycle AMCI requests
// Purpose: turns single-cycle read/write requests into handshaked AXI4-Lite
//   transactions. Independent write and read FSMs; both may be in flight.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   AMCI_W*                     write request (WADDR/WDATA/WRITE), status WIDLE/WRESP
//   AMCI_R*                     read request (RADDR/READ), status RIDLE/RDATA/RRESP
//   AXI_AW*/W*/B*               AXI4-Lite write address, data and response channels
//   AXI_AR*/R*                  AXI4-Lite read address and data channels
module axi4_lite_master
    import axi_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] AMCI_WADDR,
    input  logic [31:0] AMCI_WDATA,
    input  logic        AMCI_WRITE,
    output logic        AMCI_WIDLE,
    output logic [1:0]  AMCI_WRESP,
    input  logic [31:0] AMCI_RADDR,
    input  logic        AMCI_READ,
    output logic        AMCI_RIDLE,
    output logic [31:0] AMCI_RDATA,
    output logic [1:0]  AMCI_RRESP,
    output logic [31:0] AXI_AWADDR,
    output logic        AXI_AWVALID,
    input  logic        AXI_AWREADY,
    output logic [31:0] AXI_WDATA,
    output logic [3:0]  AXI_WSTRB,
    output logic        AXI_WVALID,
    input  logic        AXI_WREADY,
    input  logic [1:0]  AXI_BRESP,
    input  logic        AXI_BVALID,
    output logic        AXI_BREADY,
    output logic [31:0] AXI_ARADDR,
    output logic        AXI_ARVALID,
    input  logic        AXI_ARREADY,
    input  logic [31:0] AXI_RDATA,
    input  logic        AXI_RVALID,
    input  logic [1:0]  AXI_RRESP,
    output logic        AXI_RREADY
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

    // Write path state
    w_state_e    w_state_q, w_state_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [1:0]  wresp_q, wresp_d;

    // Read path state
    r_state_e    r_state_q, r_state_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            wresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            wresp_q   <= wresp_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        wresp_d   = wresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (AMCI_WRITE) begin
                    awaddr_d  = AMCI_WADDR;
                    wdata_d   = AMCI_WDATA;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    w_state_d = W_ADDR_DATA;
                end
            end
            W_ADDR_DATA: begin
                // Each VALID retires on its own handshake; a VALID already
                // low simply stays low, so the order of completion is free.
                if (AXI_AWREADY) awvalid_d = 1'b0;
                if (AXI_WREADY)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (AXI_BVALID) begin
                    wresp_d   = AXI_BRESP;
                    bready_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (AMCI_READ) begin
                    araddr_d  = AMCI_RADDR;
                    arvalid_d = 1'b1;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (AXI_RVALID) begin
                    rdata_d   = AXI_RDATA;
                    rresp_d   = AXI_RRESP;
                    rready_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign AMCI_WIDLE  = (w_state_q == W_IDLE);
    assign AMCI_WRESP  = wresp_q;
    assign AMCI_RIDLE  = (r_state_q == R_IDLE);
    assign AMCI_RDATA  = rdata_q;
    assign AMCI_RRESP  = rresp_q;
    assign AXI_AWADDR  = awaddr_q;
    assign AXI_AWVALID = awvalid_q;
    assign AXI_WDATA   = wdata_q;
    assign AXI_WSTRB   = WSTRB_ALL;
    assign AXI_WVALID  = wvalid_q;
    assign AXI_BREADY  = bready_q;
    assign AXI_ARADDR  = araddr_q;
    assign AXI_ARVALID = arvalid_q;
    assign AXI_RREADY  = rready_q;

endmodule
